vec_accumulator: RTL and testbench

VEC_ACCUMULATOR -- requirements
Module: vec_accumulator

---
 rtl/vec_accumulator_pkg.sv | 21 ++
 rtl/vec_accumulator_adder_fp16.sv | 128 ++++++++++++
 rtl/vec_accumulator.sv | 183 ++++++++++++++++++
 tb/tb_vec_accumulator.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vec_accumulator_pkg.sv
// Shared types and constants for the fp16 vector accumulator.
package vec_accumulator_pkg;

  // Reduction controller states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  // Positive zero in IEEE binary16.
  localparam logic [15:0] FP16_ZERO = 16'h0000;

  // Canonical quiet NaN produced by the adder for invalid operations.
  localparam logic [15:0] FP16_QNAN = 16'h7E00;

  // Default cycles from the adder operand register to a valid adder result.
  localparam int ADD_LAT_DEFAULT = 2;

endpackage

// File: rtl/vec_accumulator_adder_fp16.sv
// Pipelined IEEE binary16 adder/subtractor (round to nearest even).
// STAGES result registers sit behind a combinational add; res_o is valid
// STAGES cycles after op_a/op_b/mode are presented.
module adder_fp16
  import vec_accumulator_pkg::*;
#(
  parameter int STAGES = ADD_LAT_DEFAULT - 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  output logic [15:0] res_o
);

  // Full binary16 add of a + b with subnormals, infinities and NaN.
  function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y, r;
    logic        a_nan, b_nan, a_inf, b_inf, sub, rnd;
    logic [5:0]  ex, ey, e, d_full, shl;
    logic [4:0]  d, lz;
    logic [13:0] mx, my_al, nrm;
    logic [27:0] sh;
    logic [14:0] sum, packed_v;
    x = a; y = b; r = FP16_ZERO; sub = 1'b0; rnd = 1'b0;
    ex = 6'd0; ey = 6'd0; e = 6'd0; d_full = 6'd0; shl = 6'd0; d = 5'd0; lz = 5'd0;
    mx = 14'd0; my_al = 14'd0; nrm = 14'd0; sh = 28'd0; sum = 15'd0; packed_v = 15'd0;
    a_nan = (a[14:10] == 5'h1F) && (a[9:0] != 10'h000);
    b_nan = (b[14:10] == 5'h1F) && (b[9:0] != 10'h000);
    a_inf = (a[14:10] == 5'h1F) && (a[9:0] == 10'h000);
    b_inf = (b[14:10] == 5'h1F) && (b[9:0] == 10'h000);
    if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15]))) begin
      r = FP16_QNAN;
    end else if (a_inf) begin
      r = a;
    end else if (b_inf) begin
      r = b;
    end else begin
      // Order by magnitude so the difference of mantissas never goes negative.
      if (a[14:0] >= b[14:0]) begin
        x = a; y = b;
      end else begin
        x = b; y = a;
      end
      // Subnormals use exponent 1 with no hidden bit.
      ex = (x[14:10] == 5'd0) ? 6'd1 : {1'b0, x[14:10]};
      ey = (y[14:10] == 5'd0) ? 6'd1 : {1'b0, y[14:10]};
      mx = {(x[14:10] != 5'd0), x[9:0], 3'b000};
      d_full = ex - ey;
      d = (d_full > 6'd15) ? 5'd15 : d_full[4:0];
      // Align the smaller operand, folding shifted-out bits into a sticky bit.
      sh = {{(y[14:10] != 5'd0), y[9:0], 3'b000}, 14'h0000} >> d;
      my_al = {sh[27:15], sh[14] | (|sh[13:0])};
      sub = x[15] ^ y[15];
      if (sub) begin
        sum = {1'b0, mx} - {1'b0, my_al};
      end else begin
        sum = {1'b0, mx} + {1'b0, my_al};
      end
      if (sum == 15'd0) begin
        r = FP16_ZERO;
      end else begin
        if (sum[14]) begin
          nrm = {sum[14:2], sum[1] | sum[0]};
          e   = ex + 6'd1;
        end else begin
          for (int k = 0; k < 14; k++) begin
            if (sum[k]) begin
              lz = 5'(13 - k);
            end
          end
          // Never normalise below the minimum exponent: that yields a subnormal.
          if ({1'b0, lz} < (ex - 6'd1)) begin
            shl = {1'b0, lz};
          end else begin
            shl = ex - 6'd1;
          end
          nrm = sum[13:0] << shl;
          e   = ex - shl;
        end
        if (e >= 6'd31) begin
          r = {x[15], 5'h1F, 10'h000};
        end else begin
          rnd = nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
          // Rounding carry ripples into the exponent field (also subnormal->normal, max->inf).
          packed_v = {(nrm[13] ? e[4:0] : 5'd0), nrm[12:3]} + {14'd0, rnd};
          r = {x[15], packed_v};
        end
      end
    end
    return r;
  endfunction

  logic [15:0] sum_s;

  // Combinational add; subtract mode flips the sign of op_b.
  always_comb begin
    if (mode) begin
      sum_s = fp16_add(op_a, {~op_b[15], op_b[14:0]});
    end else begin
      sum_s = fp16_add(op_a, op_b);
    end
  end

  if (STAGES == 0) begin : g_comb
    assign res_o = sum_s;
  end else begin : g_pipe
    logic [15:0] pipe_q [STAGES];

    // Result pipeline registers.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int k = 0; k < STAGES; k++) begin
          pipe_q[k] <= FP16_ZERO;
        end
      end else begin
        pipe_q[0] <= sum_s;
        for (int k = 1; k < STAGES; k++) begin
          pipe_q[k] <= pipe_q[k-1];
        end
      end
    end

    assign res_o = pipe_q[STAGES-1];
  end

endmodule

// File: rtl/vec_accumulator.sv
// Sequential fp16 vector reduction: snapshots an operand vector on start and
// accumulates (or subtracts) one element per ADD_LAT+1 cycles through a
// single shared fp16 adder.
module vec_accumulator
  import vec_accumulator_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DATA_CNT   = 64,
  parameter int ADD_LAT    = ADD_LAT_DEFAULT
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic                                 abort,
  input  logic                                 mode,
  input  logic [$clog2(DATA_CNT+1)-1:0]        len,
  input  logic [DATA_CNT-1:0][DATA_WIDTH-1:0]  array,
  output logic                                 busy,
  output logic [DATA_WIDTH-1:0]                result,
  output logic                                 done
);

  localparam int LEN_W = $clog2(DATA_CNT + 1);
  localparam int IDX_W = (DATA_CNT > 1) ? $clog2(DATA_CNT) : 1;
  localparam int CNT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(DATA_CNT);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ADD_LAT - 1);

  state_e                               state_q, state_d;
  logic [DATA_CNT-1:0][DATA_WIDTH-1:0]  snap_q, snap_d;
  logic [LEN_W-1:0]                     len_q, len_d, len_cap_s;
  logic                                 mode_q, mode_d;
  logic [DATA_WIDTH-1:0]                acc_q, acc_d;
  logic [IDX_W-1:0]                     i_q, i_d;
  logic [CNT_W-1:0]                     cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]                op_a_q, op_a_d, op_b_q, op_b_d;
  logic                                 op_mode_q, op_mode_d;
  logic [DATA_WIDTH-1:0]                result_q, result_d;
  logic                                 done_q, done_d;
  logic                                 busy_q, busy_d;
  logic [DATA_WIDTH-1:0]                add_res_s;

  adder_fp16 #(
    .STAGES (ADD_LAT - 1)
  ) u_adder (
    .clk   (clk),
    .rst   (rst),
    .mode  (op_mode_q),
    .op_a  (op_a_q),
    .op_b  (op_b_q),
    .res_o (add_res_s)
  );

  // Oversized requests reduce the whole vector.
  always_comb begin
    if (len > LEN_MAX) begin
      len_cap_s = LEN_MAX;
    end else begin
      len_cap_s = len;
    end
  end

  // Controller next-state, snapshot capture, operand issue and accumulation.
  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    len_d     = len_q;
    mode_d    = mode_q;
    acc_d     = acc_q;
    i_d       = i_q;
    cnt_d     = cnt_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    op_mode_d = op_mode_q;
    case (state_q)
      S_IDLE: begin
        // abort is deliberately not looked at here: start always wins in IDLE.
        if (start) begin
          snap_d = array;
          len_d  = len_cap_s;
          mode_d = mode;
          acc_d  = FP16_ZERO;
          i_d    = '0;
          cnt_d  = '0;
          if (len_cap_s == '0) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ISSUE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          op_a_d    = acc_q;
          op_b_d    = snap_q[i_q];
          op_mode_d = mode_q;
          cnt_d     = CNT_LOAD;
          state_d   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          acc_d = add_res_s;
          i_d   = i_q + IDX_W'(1);
          if ((LEN_W'(i_q) + LEN_W'(1)) < len_q) begin
            state_d = S_ISSUE;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered outputs: result and done change together on the edge entering DONE,
  // so the done pulse and busy overlap during the DONE cycle.
  always_comb begin
    if (state_d == S_DONE) begin
      result_d = acc_d;
      done_d   = 1'b1;
    end else begin
      result_d = result_q;
      done_d   = 1'b0;
    end
    if (state_d != S_IDLE) begin
      busy_d = 1'b1;
    end else begin
      busy_d = 1'b0;
    end
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      snap_q    <= '0;
      len_q     <= '0;
      mode_q    <= 1'b0;
      acc_q     <= FP16_ZERO;
      i_q       <= '0;
      cnt_q     <= '0;
      op_a_q    <= FP16_ZERO;
      op_b_q    <= FP16_ZERO;
      op_mode_q <= 1'b0;
      result_q  <= FP16_ZERO;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      len_q     <= len_d;
      mode_q    <= mode_d;
      acc_q     <= acc_d;
      i_q       <= i_d;
      cnt_q     <= cnt_d;
      op_a_q    <= op_a_d;
      op_b_q    <= op_b_d;
      op_mode_q <= op_mode_d;
      result_q  <= result_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign busy   = busy_q;
  assign result = result_q;
  assign done   = done_q;

endmodule

// File: tb/tb_vec_accumulator.sv
// Self-checking bench for vec_accumulator. Element values are multiples of
// 0.25 kept small enough that every partial sum is exact in fp16, so the
// reference model is plain integer arithmetic in quarter units.
module tb_vec_accumulator;

  localparam int LAT = 2;

  logic                  clk;
  logic                  rst;
  logic                  start;
  logic                  abort;
  logic                  mode;
  logic [6:0]            len;
  logic [63:0][15:0]     array;
  logic                  busy;
  logic [15:0]           result;
  logic                  done;

  int checks;
  int errors;
  int elem_k [64];

  vec_accumulator #(
    .DATA_WIDTH (16),
    .DATA_CNT   (64),
    .ADD_LAT    (LAT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .abort  (abort),
    .mode   (mode),
    .len    (len),
    .array  (array),
    .busy   (busy),
    .result (result),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Exact fp16 encoding of q/4 for |q| < 2048.
  function automatic logic [15:0] q_to_fp16(input int q);
    int a;
    int p;
    logic [15:0] r;
    if (q == 0) return 16'h0000;
    a = (q < 0) ? -q : q;
    p = 0;
    for (int b = 0; b < 31; b++) begin
      if (a >= (1 << b)) p = b;
    end
    r[15]    = (q < 0);
    r[14:10] = 5'(p - 2 + 15);
    r[9:0]   = 10'((a << (10 - p)) & 32'h3FF);
    return r;
  endfunction

  // Reference reduction over the first n elements, in quarter units.
  function automatic int model_sum(input int n, input logic m);
    int s;
    s = 0;
    for (int j = 0; j < n; j++) begin
      if (m) s = s - elem_k[j];
      else   s = s + elem_k[j];
    end
    return s;
  endfunction

  // Runs one reduction; scrambles inputs right after acceptance, optionally
  // re-pulses start (with a zeroed array) or raises abort in a given cycle.
  task automatic drive_run(input int l, input logic m, input int repulse_at, input int abort_at,
                           input int max_c, output int first_done, output logic [15:0] res_done,
                           output int n_done, output int busy_cnt, output int busy_last);
    @(negedge clk);
    for (int j = 0; j < 64; j++) array[j] = q_to_fp16(elem_k[j]);
    len   = 7'(l);
    mode  = m;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int j = 0; j < 64; j++) array[j] = 16'($urandom);
    len  = 7'($urandom);
    mode = ~m;
    first_done = 0; n_done = 0; busy_cnt = 0; busy_last = 0; res_done = 16'h0000;
    for (int c = 1; c <= max_c; c++) begin
      if (busy) begin
        busy_cnt++;
        busy_last = c;
      end
      if (done) begin
        n_done++;
        if (first_done == 0) begin
          first_done = c;
          res_done   = result;
        end
      end
      start = (c == repulse_at);
      if (start) array = '0;
      abort = (c == abort_at);
      if (first_done != 0 && c >= first_done + 3) break;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    abort = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (result !== 16'h0000) begin errors++; $display("FAIL reset_result: got %h expected 0000", result); end
    @(posedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic test_sum64();
    int fd, nd, bc, bl;
    logic [15:0] rd;
    for (int j = 0; j < 64; j++) elem_k[j] = 4;
    drive_run(64, 1'b0, 0, 0, 210, fd, rd, nd, bc, bl);
    checks++; if (rd !== 16'h5400) begin errors++; $display("FAIL sum64_result: got %h expected 5400", rd); end
    checks++; if (fd !== 64 * (LAT + 1) + 1) begin errors++; $display("FAIL sum64_done_cycle: got %0d expected %0d", fd, 64 * (LAT + 1) + 1); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL sum64_done_count: got %0d expected 1", nd); end
    checks++; if (result !== 16'h5400) begin errors++; $display("FAIL sum64_hold: got %h expected 5400", result); end
  endtask

  task automatic test_neg4();
    int fd, nd, bc, bl;
    logic [15:0] rd;
    for (int j = 0; j < 64; j++) elem_k[j] = $urandom_range(0, 126) - 63;
    elem_k[0] = 4; elem_k[1] = 8; elem_k[2] = 12; elem_k[3] = 16;
    drive_run(4, 1'b1, 0, 0, 20, fd, rd, nd, bc, bl);
    checks++; if (rd !== 16'hC900) begin errors++; $display("FAIL neg4_result: got %h expected c900", rd); end
    checks++; if (fd !== 13) begin errors++; $display("FAIL neg4_done_cycle: got %0d expected 13", fd); end
    checks++; if (bc !== 13 || bl !== 13) begin errors++; $display("FAIL neg4_busy: got count %0d last %0d expected 13 13", bc, bl); end
  endtask

  task automatic test_len0();
    int fd, nd, bc, bl;
    logic [15:0] rd;
    for (int j = 0; j < 64; j++) elem_k[j] = $urandom_range(1, 63);
    drive_run(0, 1'b0, 0, 0, 10, fd, rd, nd, bc, bl);
    checks++; if (fd !== 1) begin errors++; $display("FAIL len0_done_cycle: got %0d expected 1", fd); end
    checks++; if (rd !== 16'h0000) begin errors++; $display("FAIL len0_result: got %h expected 0000", rd); end
    checks++; if (nd !== 1 || bc !== 1) begin errors++; $display("FAIL len0_pulse: got done %0d busy %0d expected 1 1", nd, bc); end
  endtask

  task automatic test_snapshot();
    int fd, nd, bc, bl;
    logic [15:0] rd;
    elem_k[0] = 4; elem_k[1] = 8; elem_k[2] = 12; elem_k[3] = 16;
    drive_run(4, 1'b0, 5, 0, 30, fd, rd, nd, bc, bl);
    checks++; if (rd !== 16'h4900) begin errors++; $display("FAIL snapshot_result: got %h expected 4900", rd); end
    checks++; if (nd !== 1) begin errors++; $display("FAIL snapshot_done_count: got %0d expected 1", nd); end
    checks++; if (fd !== 13) begin errors++; $display("FAIL snapshot_done_cycle: got %0d expected 13", fd); end
  endtask

  task automatic test_abort();
    int fd, nd, bc, bl;
    logic m;
    logic [15:0] rd, exp_r;
    drive_run(4, 1'b0, 0, 5, 20, fd, rd, nd, bc, bl);
    checks++; if (nd !== 0) begin errors++; $display("FAIL abort_no_done: got %0d expected 0", nd); end
    checks++; if (bl !== 5) begin errors++; $display("FAIL abort_busy_last: got %0d expected 5", bl); end
    checks++; if (result !== 16'h4900) begin errors++; $display("FAIL abort_result_kept: got %h expected 4900", result); end
    m = 1'($urandom_range(0, 1));
    for (int j = 0; j < 64; j++) elem_k[j] = $urandom_range(0, 126) - 63;
    exp_r = q_to_fp16(model_sum(4, m));
    drive_run(4, m, 0, 0, 20, fd, rd, nd, bc, bl);
    checks++; if (rd !== exp_r) begin errors++; $display("FAIL abort_rerun_result: got %h expected %h", rd, exp_r); end
    checks++; if (fd !== 13) begin errors++; $display("FAIL abort_rerun_cycle: got %0d expected 13", fd); end
  endtask

  task automatic test_random();
    int fd, nd, bc, bl, l;
    logic m;
    logic [15:0] rd, exp_r;
    for (int r = 0; r < 8; r++) begin
      l = $urandom_range(1, 16);
      m = 1'($urandom_range(0, 1));
      for (int j = 0; j < 64; j++) elem_k[j] = $urandom_range(0, 126) - 63;
      exp_r = q_to_fp16(model_sum(l, m));
      drive_run(l, m, 0, 0, l * (LAT + 1) + 10, fd, rd, nd, bc, bl);
      checks++; if (rd !== exp_r) begin errors++; $display("FAIL random_result[%0d]: len %0d mode %b got %h expected %h", r, l, m, rd, exp_r); end
      checks++; if (fd !== l * (LAT + 1) + 1 || nd !== 1) begin errors++; $display("FAIL random_done[%0d]: got cycle %0d count %0d expected %0d 1", r, fd, nd, l * (LAT + 1) + 1); end
    end
  endtask

  task automatic test_clamp();
    int fd, nd, bc, bl, l;
    logic m;
    logic [15:0] rd, exp_r;
    l = $urandom_range(65, 127);
    m = 1'($urandom_range(0, 1));
    for (int j = 0; j < 64; j++) elem_k[j] = 4 * ($urandom_range(0, 6) - 3);
    exp_r = q_to_fp16(model_sum(64, m));
    drive_run(l, m, 0, 0, 210, fd, rd, nd, bc, bl);
    checks++; if (rd !== exp_r) begin errors++; $display("FAIL clamp_result: len %0d got %h expected %h", l, rd, exp_r); end
    checks++; if (fd !== 64 * (LAT + 1) + 1) begin errors++; $display("FAIL clamp_done_cycle: got %0d expected %0d", fd, 64 * (LAT + 1) + 1); end
  endtask

  task automatic test_reset_mid();
    int fd, nd, bc, bl;
    logic [15:0] rd;
    elem_k[0] = 4; elem_k[1] = 8; elem_k[2] = 12; elem_k[3] = 16;
    drive_run(4, 1'b0, 0, 0, 20, fd, rd, nd, bc, bl);
    checks++; if (rd !== 16'h4900) begin errors++; $display("FAIL rstmid_pre_result: got %h expected 4900", rd); end
    @(negedge clk);
    for (int j = 0; j < 64; j++) array[j] = q_to_fp16(elem_k[j]);
    len = 7'd4; mode = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rstmid_flags: got busy %b done %b expected 0 0", busy, done); end
    checks++; if (result !== 16'h0000) begin errors++; $display("FAIL rstmid_result: got %h expected 0000", result); end
    @(posedge clk);
    #2 rst = 1'b1;
    elem_k[0] = 6;
    drive_run(1, 1'b0, 0, 0, 12, fd, rd, nd, bc, bl);
    checks++; if (rd !== 16'h3E00) begin errors++; $display("FAIL rstmid_post_result: got %h expected 3e00", rd); end
    checks++; if (fd !== 4 || nd !== 1) begin errors++; $display("FAIL rstmid_post_done: got cycle %0d count %0d expected 4 1", fd, nd); end
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Test sequence.
  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    mode   = 1'b0;
    len    = 7'd0;
    array  = '0;
    repeat (3) @(posedge clk);
    test_reset();
    test_sum64();
    test_neg4();
    test_len0();
    test_snapshot();
    test_abort();
    test_random();
    test_clamp();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
